// File: rtl/render_pkg.sv
// render_pkg: shared projected-triangle types and default triangle FIFO depth
package render_pkg;
  typedef logic [1:0][9:0] proj_vertex_t;
  typedef logic [2:0][1:0][9:0] proj_tri_t;
  localparam int TRI_FIFO_DEPTH = 16;
endpackage

// File: rtl/tri_fifo_mem.sv
// tri_fifo_mem: triangle storage array, one write port, one async read port
module tri_fifo_mem
  import render_pkg::*;
#(
  parameter int DEPTH = TRI_FIFO_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  proj_tri_t     wdata,
  input  logic [AW-1:0] raddr,
  output proj_tri_t     rdata
);
  proj_tri_t mem [DEPTH];
  always_ff @(posedge Clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/triangle_fifo.sv
// triangle_fifo: first-word-fall-through queue of projected triangles with sticky error flags
module triangle_fifo
  import render_pkg::*;
#(
  parameter int DEPTH = TRI_FIFO_DEPTH
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     flush,
  input  logic                     fifo_w,
  input  proj_tri_t                proj_triangle_in,
  input  logic                     fifo_r,
  output proj_tri_t                proj_triangle_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic rd_ok, wr_ok;
  proj_tri_t head;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign rd_ok = fifo_r & ~empty;
  // a pop in the same cycle frees the slot a full-FIFO write needs
  assign wr_ok = fifo_w & (~full | rd_ok);
  assign proj_triangle_out = empty ? '0 : head;
  tri_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .Clk  (Clk),
    .we   (wr_ok & ~flush),
    .waddr(wr_ptr),
    .wdata(proj_triangle_in),
    .raddr(rd_ptr),
    .rdata(head)
  );
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_ok) - CW'(rd_ok);
      if (fifo_w & ~wr_ok) overflow <= 1'b1;
      if (fifo_r & empty) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_triangle_fifo.sv
// tb_triangle_fifo: directed checks of the triangle FIFO with immediate assertions
module tb_triangle_fifo;
  import render_pkg::*;
  logic Clk, Reset, flush, fifo_w, fifo_r;
  proj_tri_t proj_triangle_in, proj_triangle_out, t0;
  logic empty, full, overflow, underflow;
  logic [4:0] count;
  int checks = 0;
  int errors = 0;

  triangle_fifo #(.DEPTH(16)) dut (
    .Clk(Clk), .Reset(Reset), .flush(flush), .fifo_w(fifo_w),
    .proj_triangle_in(proj_triangle_in), .fifo_r(fifo_r),
    .proj_triangle_out(proj_triangle_out), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic proj_tri_t mk(input int k);
    proj_tri_t t;
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 2; c++) t[v][c] = 10'(k * 8 + v * 2 + c);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b0; flush = 1'b0; fifo_w = 1'b0; fifo_r = 1'b0; proj_triangle_in = '0;
    #3;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_out", proj_triangle_out, 0);
    chk("rst_flags", {overflow, underflow}, 0);
    #9 Reset = 1'b1;
    step();
    // single write, one-cycle latency, then pop
    t0[0][0] = 10'd100; t0[0][1] = 10'd140;
    t0[1][0] = 10'd140; t0[1][1] = 10'd120;
    t0[2][0] = 10'd120; t0[2][1] = 10'd160;
    fifo_w = 1'b1; proj_triangle_in = t0;
    #1 chk("no_bypass", {empty, proj_triangle_out}, {1'b1, 60'd0});
    step(); fifo_w = 1'b0;
    chk("w1_empty", empty, 0);
    chk("w1_count", count, 1);
    chk("w1_out", proj_triangle_out, t0);
    fifo_r = 1'b1;
    step(); fifo_r = 1'b0;
    chk("pop1_empty", empty, 1);
    chk("pop1_out", proj_triangle_out, 0);
    chk("pop1_uflow", underflow, 0);
    // fill to 16, then overflow
    for (int i = 0; i < 16; i++) begin
      fifo_w = 1'b1; proj_triangle_in = mk(i);
      step();
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_oflow0", overflow, 0);
    proj_triangle_in = mk(99);
    step(); fifo_w = 1'b0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 16);
    chk("ovf_head", proj_triangle_out, mk(0));
    // simultaneous read and write while full
    fifo_w = 1'b1; fifo_r = 1'b1; proj_triangle_in = mk(50);
    step(); fifo_w = 1'b0; fifo_r = 1'b0;
    chk("frw_count", count, 16);
    chk("frw_full", full, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), proj_triangle_out, i < 15 ? mk(i + 1) : mk(50));
      fifo_r = 1'b1;
      step();
    end
    fifo_r = 1'b0;
    chk("drain_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);
    // read and write together while empty
    fifo_w = 1'b1; fifo_r = 1'b1; proj_triangle_in = mk(60);
    step(); fifo_w = 1'b0; fifo_r = 1'b0;
    chk("erw_uflow", underflow, 1);
    chk("erw_count", count, 1);
    chk("erw_out", proj_triangle_out, mk(60));
    // flush beats a concurrent write
    flush = 1'b1; fifo_w = 1'b1; proj_triangle_in = mk(61);
    step(); flush = 1'b0; fifo_w = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_flags", {overflow, underflow}, 0);
    chk("fl_out", proj_triangle_out, 0);
    step();
    chk("fl_wr_ignored", count, 0);
    // steady streaming at depth 3 across the pointer wrap
    for (int i = 0; i < 3; i++) begin
      fifo_w = 1'b1; proj_triangle_in = mk(70 + i);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      fifo_w = 1'b1; fifo_r = 1'b1; proj_triangle_in = mk(80 + i);
      chk($sformatf("stream_%0d", i), proj_triangle_out, i < 3 ? mk(70 + i) : mk(77 + i));
      step();
    end
    fifo_w = 1'b0; fifo_r = 1'b0;
    chk("stream_count", count, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tail_%0d", i), proj_triangle_out, mk(97 + i));
      fifo_r = 1'b1;
      step();
    end
    fifo_r = 1'b0;
    chk("tail_empty", empty, 1);
    // async reset mid-cycle at count 5 with a flag set
    fifo_r = 1'b1;
    step(); fifo_r = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fifo_w = 1'b1; proj_triangle_in = mk(i + 1);
      step();
    end
    fifo_w = 1'b0;
    chk("pre_count", count, 5);
    chk("pre_uflow", underflow, 1);
    #2 Reset = 1'b0;
    #1;
    chk("ares_empty", empty, 1);
    chk("ares_count", count, 0);
    chk("ares_flags", {overflow, underflow}, 0);
    chk("ares_out", proj_triangle_out, 0);
    #1 Reset = 1'b1;
    fifo_w = 1'b1; proj_triangle_in = mk(7);
    step(); fifo_w = 1'b0;
    chk("post_count", count, 1);
    chk("post_out", proj_triangle_out, mk(7));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
